mux4to1_using_decoder: RTL and testbench
========================================

Name: mux4to1_using_decoder

Overview:
- Registered 4-to-1 multiplexer for WIDTH-bit data words.
- Built as a 2-to-4 one-hot decoder on the select input that gates four data inputs through an AND-OR plane.
- A general-purpose datapath selector; the registered one-hot decode is also exported for downstream status and debug.

Parameters:
- WIDTH, 4, bit width of each data input and of the output y.

Ports:
- clk  input  1  rising-edge clock; the only clock.
- rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk.
- en  input  1  capture enable; when high, output registers load on the clock edge.
- sel  input  2  select: 00->a, 01->b, 10->c, 11->d.
- a  input  WIDTH  data input 0.
- b  input  WIDTH  data input 1.
- c  input  WIDTH  data input 2.
- d  input  WIDTH  data input 3.
- y  output  WIDTH  registered selected data.
- dec  output  4  registered one-hot decode of sel (bit i set when sel==i).

Behaviour:
- Interface: one clock (clk); reset rst_n is synchronous and active-low. No asynchronous paths into the registers.
- Decoder, combinational:
  - dec_c = 4'b0001 << sel, so 00->0001, 01->0010, 10->0100, 11->1000.
  - dec_c is always exactly one-hot.
- Select plane, combinational:
  - y_c = (a & {WIDTH{dec_c[0]}}) | (b & {WIDTH{dec_c[1]}}) | (c & {WIDTH{dec_c[2]}}) | (d & {WIDTH{dec_c[3]}}).
  - Must be implemented via the decoder output, not a case on sel. Functionally equivalent to a plain 4:1 mux.
- Registers, updated on the rising edge of clk:
  - rst_n==0: y<=0, dec<=4'b0000. Reset has priority over en.
  - rst_n==1 and en==1: y<=y_c, dec<=dec_c.
  - rst_n==1 and en==0: y and dec hold their previous values.
- Latency:
  - Exactly 1 clock from sel/data/en sampled to y/dec updated.
  - No combinational path from any input to any output.
- Reset values: y = all zeros, dec = 0000. dec==0000 is the only non-one-hot value and signifies "reset, not yet loaded".
- Reset mid-operation: on the first edge with rst_n low, outputs clear regardless of en or inputs. On the first edge after rst_n returns high with en high, outputs load normally; no extra warm-up cycles.
- Data changes with sel unchanged: y follows the newly selected input on the next enabled edge.
- Select changes with data unchanged: y switches to the new source on the next enabled edge with no intermediate value.
- Width: all data paths are exactly WIDTH bits. No extension or truncation.
- Unknown or X values on sel are not defined behaviour; the bench need not check them.

Test Plan:
- Reset: rst_n=0 for 2 edges with en=1, sel=11, d=0110 -> y=0000, dec=0000; release -> next edge y=0110, dec=1000.
- Sweep, WIDTH=4, en=1, a=1100 b=1010 c=0011 d=0110: sel 00/01/10/11 on successive edges -> y=1100/1010/0011/0110 one edge later; dec=0001/0010/0100/1000.
- Second data set: a=0010 b=1000 c=0100 d=0110, sweep sel 00..11 -> y=0010/1000/0100/0110. Third set: a=1111 b=1110 c=1100 d=0001 with sel 00 then 01 -> y=1111 then 1110.
- Enable hold: with y=1111 (sel=00), set en=0, change sel=11 and d=0001 for 3 edges -> y stays 1111 and dec stays 0001; re-assert en -> next edge y=0001, dec=1000.
- Reset mid-stream: y=1010 during a sweep, assert rst_n=0 for one edge with en=1 -> y=0000, dec=0000; deassert -> resumes selecting on the following edge.
- Data-only change: sel=10 held, c changes 0011->0100 -> y changes 0011->0100 exactly one edge later; dec stays 0100.

Source files
------------

// File: rtl/mux4to1_using_decoder_if.sv
// Bus bundle for the registered decoder-based 4:1 selector: capture enable,
// select and data toward the block, registered result and decode back.
interface mux4to1_using_decoder_if #(
    parameter int WIDTH = 4
);
    logic             en;
    logic [1:0]       sel;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] c;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] y;
    logic [3:0]       dec;

    modport master (
        output en, sel, a, b, c, d,
        input  y, dec
    );

    modport slave (
        input  en, sel, a, b, c, d,
        output y, dec
    );
endinterface

// File: rtl/mux4to1_using_decoder.sv
// Registered 4:1 selector: a 2-to-4 one-hot decode of sel gates the data
// words through an AND-OR plane; the result and the decode are both registered.
module mux4to1_using_decoder #(
    parameter int WIDTH = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    mux4to1_using_decoder_if.slave    bus
);

    logic [3:0]       dec_s;
    logic [WIDTH-1:0] y_s;
    logic [3:0]       dec_r;
    logic [WIDTH-1:0] y_r;

    function automatic logic [3:0] decode_2to4(input logic [1:0] s);
        return 4'b0001 << s;
    endfunction

    // Decode sel and gate each data word with its one-hot enable.
    always_comb begin
        dec_s = decode_2to4(bus.sel);
        y_s   = (bus.a & {WIDTH{dec_s[0]}})
              | (bus.b & {WIDTH{dec_s[1]}})
              | (bus.c & {WIDTH{dec_s[2]}})
              | (bus.d & {WIDTH{dec_s[3]}});
    end

    // Output registers; dec_r == 0 marks "reset, not yet loaded".
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            y_r   <= {WIDTH{1'b0}};
            dec_r <= 4'b0000;
        end else if (bus.en) begin
            y_r   <= y_s;
            dec_r <= dec_s;
        end else begin
            y_r   <= y_r;
            dec_r <= dec_r;
        end
    end

    assign bus.y   = y_r;
    assign bus.dec = dec_r;

endmodule

// File: tb/tb_mux4to1_using_decoder.sv
// Self-checking bench: directed scenarios followed by random traffic, all
// compared against a behavioural model of the registered selector.
module tb_mux4to1_using_decoder;

    localparam int WIDTH = 4;

    logic clk;
    logic rst_n;
    int   chk_cnt;
    int   pass_cnt;

    logic [WIDTH-1:0] mdl_y;
    logic [3:0]       mdl_dec;

    mux4to1_using_decoder_if #(.WIDTH(WIDTH)) bus_if ();

    mux4to1_using_decoder #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got %0d/%0d checks", pass_cnt, chk_cnt);
        $fatal(1);
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: on an edge, reset clears; otherwise an enabled edge picks
    // word number sel out of {a,b,c,d} and records which one as a set bit.
    task automatic model_edge();
        logic [WIDTH-1:0] words [4];
        words[0] = bus_if.a;
        words[1] = bus_if.b;
        words[2] = bus_if.c;
        words[3] = bus_if.d;
        if (rst_n == 1'b0) begin
            mdl_y   = '0;
            mdl_dec = 4'd0;
        end else if (bus_if.en == 1'b1) begin
            mdl_y   = words[int'(bus_if.sel)];
            mdl_dec = 4'(2 ** int'(bus_if.sel));
        end
    endtask

    // Drive one cycle of inputs (called at a falling edge), clock it, check.
    task automatic cycle(input string tag, input logic r, input logic e, input logic [1:0] s,
                         input logic [3:0] va, input logic [3:0] vb,
                         input logic [3:0] vc, input logic [3:0] vd);
        rst_n      = r;
        bus_if.en  = e;
        bus_if.sel = s;
        bus_if.a   = va;
        bus_if.b   = vb;
        bus_if.c   = vc;
        bus_if.d   = vd;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_val({tag, "_y"}, 32'(bus_if.y), 32'(mdl_y));
        check_val({tag, "_dec"}, 32'(bus_if.dec), 32'(mdl_dec));
    endtask

    initial begin
        chk_cnt  = 0;
        pass_cnt = 0;
        mdl_y    = '0;
        mdl_dec  = 4'd0;
        rst_n    = 1'b0;
        bus_if.en = 1'b0; bus_if.sel = 2'd0;
        bus_if.a = '0; bus_if.b = '0; bus_if.c = '0; bus_if.d = '0;
        @(negedge clk);

        // Reset with en high, then release.
        cycle("rst0", 1'b0, 1'b1, 2'b11, 4'h0, 4'h0, 4'h0, 4'b0110);
        cycle("rst1", 1'b0, 1'b1, 2'b11, 4'h0, 4'h0, 4'h0, 4'b0110);
        check_val("rst_y_const", 32'(bus_if.y), 32'h0);
        check_val("rst_dec_const", 32'(bus_if.dec), 32'h0);
        cycle("rel", 1'b1, 1'b1, 2'b11, 4'h0, 4'h0, 4'h0, 4'b0110);
        check_val("rel_y_const", 32'(bus_if.y), 32'b0110);
        check_val("rel_dec_const", 32'(bus_if.dec), 32'b1000);

        // Sweeps over three data sets.
        for (int s = 0; s < 4; s++)
            cycle("sw1", 1'b1, 1'b1, 2'(s), 4'b1100, 4'b1010, 4'b0011, 4'b0110);
        check_val("sw1_last_const", 32'(bus_if.y), 32'b0110);
        for (int s = 0; s < 4; s++)
            cycle("sw2", 1'b1, 1'b1, 2'(s), 4'b0010, 4'b1000, 4'b0100, 4'b0110);
        cycle("sw3a", 1'b1, 1'b1, 2'b00, 4'b1111, 4'b1110, 4'b1100, 4'b0001);
        check_val("sw3a_const", 32'(bus_if.y), 32'b1111);
        cycle("sw3b", 1'b1, 1'b1, 2'b01, 4'b1111, 4'b1110, 4'b1100, 4'b0001);
        check_val("sw3b_const", 32'(bus_if.y), 32'b1110);

        // Enable hold.
        cycle("hold_pre", 1'b1, 1'b1, 2'b00, 4'b1111, 4'b1110, 4'b1100, 4'b0110);
        for (int i = 0; i < 3; i++)
            cycle("hold", 1'b1, 1'b0, 2'b11, 4'b1111, 4'b1110, 4'b1100, 4'b0001);
        check_val("hold_y_const", 32'(bus_if.y), 32'b1111);
        check_val("hold_dec_const", 32'(bus_if.dec), 32'b0001);
        cycle("hold_rel", 1'b1, 1'b1, 2'b11, 4'b1111, 4'b1110, 4'b1100, 4'b0001);
        check_val("hold_rel_const", 32'(bus_if.y), 32'b0001);

        // Reset mid-stream.
        cycle("mid_a", 1'b1, 1'b1, 2'b01, 4'b1100, 4'b1010, 4'b0011, 4'b0110);
        check_val("mid_pre_const", 32'(bus_if.y), 32'b1010);
        cycle("mid_rst", 1'b0, 1'b1, 2'b10, 4'b1100, 4'b1010, 4'b0011, 4'b0110);
        check_val("mid_rst_const", 32'(bus_if.dec), 32'h0);
        cycle("mid_rel", 1'b1, 1'b1, 2'b10, 4'b1100, 4'b1010, 4'b0011, 4'b0110);
        check_val("mid_rel_const", 32'(bus_if.y), 32'b0011);

        // Data-only change with sel held.
        cycle("data_chg", 1'b1, 1'b1, 2'b10, 4'b1100, 4'b1010, 4'b0100, 4'b0110);
        check_val("data_chg_const", 32'(bus_if.y), 32'b0100);
        check_val("data_dec_const", 32'(bus_if.dec), 32'b0100);

        // Random traffic with occasional reset and enable drops.
        for (int i = 0; i < 300; i++) begin
            cycle("rand", ($urandom_range(0, 19) != 0), ($urandom_range(0, 3) != 0),
                  2'($urandom_range(0, 3)), 4'($urandom), 4'($urandom),
                  4'($urandom), 4'($urandom));
        end

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
